// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared PC-source and FSM encodings for the fetch PC controller.
// Fetch-address checking is enabled with FETCH_ADDR_CHK_EN.
package fetch_pc_ctrl_pkg;

    localparam logic [2:0] PCSEL_PCA4   = 3'd0;
    localparam logic [2:0] PCSEL_BRANCH = 3'd1;
    localparam logic [2:0] PCSEL_J      = 3'd2;
    localparam logic [2:0] PCSEL_JR     = 3'd3;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch handshake: req/addr from the PC unit, gnt from IM.
// Fetch-address checking is enabled with FETCH_ADDR_CHK_EN.
interface fetch_pc_ctrl_if #(
    parameter int PC_W = 32
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            gnt;

    modport master (
        output req,
        output addr,
        input  gnt
    );

    modport slave (
        input  req,
        input  addr,
        output gnt
    );
endinterface

// File: rtl/fetch_pc_ctrl_pc_target_calc.sv
// D-stage redirect target (jr / taken branch / j) and redirect flag.
// Fetch-address checking is enabled with FETCH_ADDR_CHK_EN.
module pc_target_calc
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [2:0]      pcsel,
    input  logic            branch,
    input  logic [25:0]     imm26,
    input  logic [15:0]     offset16,
    input  logic [PC_W-1:0] ra,
    input  logic [PC_W-1:0] d_pc,
    output logic [PC_W-1:0] d_tgt,
    output logic            d_redirect
);

    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] j_tgt;
    logic [17:0]     off18;
    logic            is_jr;
    logic            is_br;
    logic            is_j;

    assign off18  = {offset16, 2'b00};
    assign br_tgt = d_pc + PC_W'(4) + PC_W'($signed(off18));

    // Narrow PCs have no region bits above the 28-bit j field.
    if (PC_W > 28) begin : g_j_wide
        assign j_tgt = {d_pc[PC_W-1:28], imm26, 2'b00};
    end else begin : g_j_narrow
        assign j_tgt = PC_W'({imm26, 2'b00});
    end

    assign is_jr = (pcsel == PCSEL_JR);
    assign is_br = (pcsel == PCSEL_BRANCH) && branch;
    assign is_j  = (pcsel == PCSEL_J);

    always_comb begin
        d_tgt      = '0;
        d_redirect = 1'b0;
        unique case (1'b1)
            is_jr: begin
                d_tgt      = ra;
                d_redirect = 1'b1;
            end
            is_br: begin
                d_tgt      = br_tgt;
                d_redirect = 1'b1;
            end
            is_j: begin
                d_tgt      = j_tgt;
                d_redirect = 1'b1;
            end
            default: begin
                d_tgt      = '0;
                d_redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC register, redirect priority, pending redirect and IM fetch FSM.
// Define FETCH_ADDR_CHK_EN to flag misaligned/out-of-text fetch addresses.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(32'h0000_4180),
    parameter logic [PC_W-1:0] ERET_OFS = '0,
    parameter logic [PC_W-1:0] TEXT_LO  = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] TEXT_HI  = PC_W'(32'h0000_6FFF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            req,
    input  logic            eret,
    input  logic [PC_W-1:0] epc,
    input  logic [2:0]      pcsel,
    input  logic            branch,
    input  logic [25:0]     imm26,
    input  logic [15:0]     offset16,
    input  logic [PC_W-1:0] ra,
    input  logic [PC_W-1:0] D_pc,
    fetch_pc_ctrl_if.master im,
    output logic [PC_W-1:0] F_pc,
    output logic            F_valid,
    output logic            F_exc_adel
);

    if (PC_W < 16 || TEXT_LO > TEXT_HI) begin : g_bad_cfg
        $error("fetch_pc_ctrl: bad PC_W or text window");
    end

    fetch_state_e    state;
    fetch_state_e    state_nx;
    logic            pend_v;
    logic [PC_W-1:0] pend_tgt;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] d_tgt;
    logic            d_redirect;
    logic            redirect;
    logic [PC_W-1:0] tgt;
    logic            fetch_ok;

    pc_target_calc #(
        .PC_W(PC_W)
    ) u_tgt (
        .pcsel     (pcsel),
        .branch    (branch),
        .imm26     (imm26),
        .offset16  (offset16),
        .ra        (ra),
        .d_pc      (D_pc),
        .d_tgt     (d_tgt),
        .d_redirect(d_redirect)
    );

    // CP0 sources win over the D stage and are not blocked by stall.
    always_comb begin
        redirect = 1'b1;
        tgt      = '0;
        if (req) begin
            tgt = EXC_VEC;
        end else if (eret) begin
            tgt = epc + ERET_OFS;
        end else if (!stall && d_redirect) begin
            tgt = d_tgt;
        end else begin
            redirect = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:    state_nx = FETCH;
            FETCH:   state_nx = FETCH;
            default: state_nx = BOOT;
        endcase
    end

    assign fetch_ok = im.gnt && (state == FETCH);

    always_comb begin
        pc_nx = F_pc;
        if (redirect) begin
            pc_nx = tgt;
        end else if (pend_v) begin
            pc_nx = pend_tgt;
        end else if (!stall) begin
            pc_nx = F_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            F_pc     <= RESET_PC;
            pend_v   <= 1'b0;
            pend_tgt <= '0;
        end else begin
            state <= state_nx;
            if (fetch_ok) begin
                F_pc   <= pc_nx;
                pend_v <= 1'b0;
            end else if (redirect) begin
                pend_v   <= 1'b1;
                pend_tgt <= tgt;
            end
        end
    end

    assign im.req  = (state == FETCH);
    assign im.addr = F_pc;

    // The word returned this cycle is wrong-path if any redirect is in flight.
    assign F_valid = im.gnt && im.req && !redirect && !pend_v;

`ifdef FETCH_ADDR_CHK_EN
    assign F_exc_adel = (F_pc[1:0] != 2'b00)
                      || (F_pc < TEXT_LO)
                      || (F_pc > TEXT_HI);
`else
    assign F_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed scoreboard bench for fetch_pc_ctrl.
// Build with FETCH_ADDR_CHK_EN defined to exercise the address check.
module tb_fetch_pc_ctrl;
    import fetch_pc_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        ireq;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, req, eret, branch;
    logic [31:0] epc, ra, d_pc;
    logic [2:0]  pcsel;
    logic [25:0] imm26;
    logic [15:0] offset16;
    logic [31:0] f_pc;
    logic        f_valid, f_exc_adel;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    fetch_pc_ctrl_if #(.PC_W(32)) im_bus ();

    fetch_pc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .eret      (eret),
        .epc       (epc),
        .pcsel     (pcsel),
        .branch    (branch),
        .imm26     (imm26),
        .offset16  (offset16),
        .ra        (ra),
        .D_pc      (d_pc),
        .im        (im_bus),
        .F_pc      (f_pc),
        .F_valid   (f_valid),
        .F_exc_adel(f_exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic exp_adel(logic [31:0] pc);
`ifdef FETCH_ADDR_CHK_EN
        return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Push the expected outputs for the current cycle, then advance one clock.
    task automatic cyc(logic [31:0] pc, logic v, logic rq);
        exp_t e;
        e.pc    = pc;
        e.valid = v;
        e.ireq  = rq;
        e.adel  = exp_adel(pc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("F_pc", f_pc, e.pc);
            cmp("im_addr", im_bus.addr, e.pc);
            cmp("F_valid", 32'(f_valid), 32'(e.valid));
            cmp("im_req", 32'(im_bus.req), 32'(e.ireq));
            cmp("F_exc_adel", 32'(f_exc_adel), 32'(e.adel));
        end
    end

    initial begin
        reset = 1'b0;
        stall = 1'b0; req = 1'b0; eret = 1'b0; branch = 1'b0;
        epc = '0; ra = '0; d_pc = '0; imm26 = '0; offset16 = '0;
        pcsel = PCSEL_PCA4;
        im_bus.gnt = 1'b1;
        @(posedge clk);
        #1;

        cyc(32'h3000, 0, 0);
        reset = 1'b1;
        cyc(32'h3000, 0, 0);
        cyc(32'h3000, 1, 1);
        cyc(32'h3004, 1, 1);

        d_pc = 32'h3010; pcsel = PCSEL_BRANCH; branch = 1'b1; offset16 = 16'hFFFE;
        cyc(32'h3008, 0, 1);
        branch = 1'b0;
        cyc(32'h300C, 1, 1);
        pcsel = PCSEL_PCA4;
        cyc(32'h3010, 1, 1);

        stall = 1'b1; pcsel = PCSEL_JR; ra = 32'h3400;
        cyc(32'h3014, 1, 1);
        cyc(32'h3014, 1, 1);
        req = 1'b1;
        cyc(32'h3014, 0, 1);
        req = 1'b0; stall = 1'b0; pcsel = PCSEL_PCA4;
        cyc(32'h4180, 1, 1);

        im_bus.gnt = 1'b0; pcsel = PCSEL_J; imm26 = 26'h0000D00; d_pc = 32'h3000;
        cyc(32'h4184, 0, 1);
        im_bus.gnt = 1'b1; pcsel = PCSEL_PCA4;
        cyc(32'h4184, 0, 1);
        cyc(32'h3400, 1, 1);

        im_bus.gnt = 1'b0; pcsel = PCSEL_J;
        cyc(32'h3404, 0, 1);
        pcsel = PCSEL_PCA4; req = 1'b1;
        cyc(32'h3404, 0, 1);
        req = 1'b0;
        cyc(32'h3404, 0, 1);
        im_bus.gnt = 1'b1;
        cyc(32'h3404, 0, 1);
        cyc(32'h4180, 1, 1);

        eret = 1'b1; epc = 32'h3100;
        cyc(32'h4184, 0, 1);
        eret = 1'b0;
        cyc(32'h3100, 1, 1);
        req = 1'b1; eret = 1'b1; stall = 1'b1;
        cyc(32'h3104, 0, 1);
        req = 1'b0; eret = 1'b0;
        cyc(32'h4180, 1, 1);
        stall = 1'b0;
        cyc(32'h4180, 1, 1);

        pcsel = PCSEL_JR; ra = 32'h3002;
        cyc(32'h4184, 0, 1);
        ra = 32'h7000;
        cyc(32'h3002, 0, 1);
        ra = 32'h6FFC;
        cyc(32'h7000, 0, 1);
        ra = 32'h2FFC;
        cyc(32'h6FFC, 0, 1);
        pcsel = PCSEL_PCA4;
        cyc(32'h2FFC, 1, 1);
        pcsel = PCSEL_JR; ra = 32'hFFFF_FFFC;
        cyc(32'h3000, 0, 1);
        pcsel = PCSEL_PCA4;
        cyc(32'hFFFF_FFFC, 1, 1);
        cyc(32'h0000_0000, 1, 1);

        im_bus.gnt = 1'b0; pcsel = PCSEL_J; imm26 = 26'h0000D00; d_pc = 32'h3000;
        cyc(32'h0000_0004, 0, 1);
        reset = 1'b0;
        cyc(32'h3000, 0, 0);
        pcsel = PCSEL_PCA4; im_bus.gnt = 1'b1;
        cyc(32'h3000, 0, 0);
        reset = 1'b1;
        cyc(32'h3000, 0, 0);
        cyc(32'h3000, 1, 1);
        cyc(32'h3004, 1, 1);

        repeat (3) @(posedge clk);
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
